// File: rtl/io_block_mover.sv
// Bus-master copy engine: moves word_count 32-bit words from src_addr to dst_addr
// over the I/O chip-select/read/write port, then raises intr until inta.
module io_block_mover #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             inta,
  input  logic [31:0]      io_din,
  output logic [31:0]      io_addr,
  output logic [31:0]      io_dout,
  output logic             io_cs,
  output logic             io_rd,
  output logic             io_wr,
  output logic             busy,
  output logic             intr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    INTR  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      src_reg, src_next;
  logic [31:0]      dst_reg, dst_next;
  logic [31:0]      data_reg, data_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      data_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Outputs depend only on registered state, so no input reaches an output combinationally.
  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    io_addr    = '0;
    io_dout    = '0;
    io_cs      = 1'b0;
    io_rd      = 1'b0;
    io_wr      = 1'b0;
    busy       = 1'b0;
    intr       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          src_next   = src_addr;
          dst_next   = dst_addr;
          cnt_next   = word_count;
          state_next = (word_count == '0) ? INTR : READ;
        end
      end
      READ: begin
        io_cs      = 1'b1;
        io_rd      = 1'b1;
        io_addr    = src_reg;
        busy       = 1'b1;
        data_next  = io_din;
        state_next = WRITE;
      end
      WRITE: begin
        io_cs      = 1'b1;
        io_wr      = 1'b1;
        io_addr    = dst_reg;
        io_dout    = data_reg;
        busy       = 1'b1;
        // Plain 32-bit adds: addresses wrap modulo 2^32 and keep their low bits.
        src_next   = src_reg + 32'd4;
        dst_next   = dst_reg + 32'd4;
        cnt_next   = cnt_reg - 1'b1;
        state_next = (cnt_reg == CNT_W'(1)) ? INTR : READ;
      end
      INTR: begin
        busy = 1'b1;
        intr = 1'b1;
        if (inta) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_io_block_mover.sv
// Scoreboarded bench for io_block_mover: a word-addressed memory responder,
// a queue-based reference model of the copy, and a negedge bus monitor.
module tb_io_block_mover;
  localparam int CNT_W = 10;

  logic             clk = 1'b0;
  logic             reset, start, inta;
  logic [31:0]      src_addr, dst_addr;
  logic [CNT_W-1:0] word_count;
  logic [31:0]      io_din = 32'h0;
  logic [31:0]      io_addr, io_dout;
  logic             io_cs, io_rd, io_wr, busy, intr;

  io_block_mover #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_count(word_count), .inta(inta), .io_din(io_din), .io_addr(io_addr),
    .io_dout(io_dout), .io_cs(io_cs), .io_rd(io_rd), .io_wr(io_wr), .busy(busy), .intr(intr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bus_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } txn_t;

  txn_t exp_q[$];
  int   exp_intr_q[$];

  logic [31:0] mem     [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a[31:2])) return mem[a[31:2]];
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    mem[a[31:2]]     = v;
    ref_mem[a[31:2]] = v;
  endtask

  // Memory responder: strobes are stable mid-cycle, so the write is taken and the
  // read data presented at the falling edge; writes are suppressed while reset is high.
  initial forever begin
    @(negedge clk);
    if (io_cs && io_wr && !reset) mem[io_addr[31:2]] = io_dout;
    io_din = (io_cs && io_rd) ? mem_rd(io_addr) : 32'h0;
  end

  // Monitor: every bus cycle and every intr rise is matched against the scoreboard.
  initial begin
    logic intr_prev = 1'b0;
    txn_t t;
    forever begin
      @(negedge clk);
      if (io_cs) begin
        bus_cnt++;
        chk("rd_wr_exclusive", 32'(io_rd & io_wr), 32'h0);
        chk("busy_during_bus", 32'(busy), 32'h1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_bus rd=%b wr=%b addr=%h required=no_access (cycle %0d)",
                   io_rd, io_wr, io_addr, cyc);
        end else begin
          t = exp_q.pop_front();
          chk("bus_kind", 32'({io_rd, io_wr}), t.wr ? 32'h1 : 32'h2);
          chk("bus_addr", io_addr, t.addr);
          chk("bus_cycle", 32'(cyc), 32'(t.cyc));
          if (t.wr) chk("bus_wdata", io_dout, t.data);
        end
      end
      if (intr && !intr_prev) begin
        if (exp_intr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_intr actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          chk("intr_cycle", 32'(cyc), 32'(exp_intr_q.pop_front()));
        end
      end
      intr_prev = intr;
    end
  end

  // Reference model: sequential word copy over ref_mem; cycle 1 of the transfer is 'base'.
  task automatic push_xfer(input logic [31:0] s, input logic [31:0] d, input int n, input int base);
    txn_t t;
    logic [31:0] w;
    for (int k = 0; k < n; k++) begin
      w = ref_rd(s + 32'(4 * k));
      t.wr = 1'b0; t.addr = s + 32'(4 * k); t.data = 32'h0; t.cyc = base + 2 * k;
      exp_q.push_back(t);
      t.wr = 1'b1; t.addr = d + 32'(4 * k); t.data = w; t.cyc = base + 2 * k + 1;
      exp_q.push_back(t);
      ref_mem[t.addr[31:2]] = w;
    end
    exp_intr_q.push_back(base + 2 * n);
  endtask

  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n,
                          input int hold, input bit spurious, input bit start_with_inta);
    int base, b0;
    bit got;
    src_addr = s; dst_addr = d; word_count = CNT_W'(n); start = 1'b1;
    b0 = bus_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    base = cyc;
    push_xfer(s, d, n, base);
    chk("busy_cycle1", 32'(busy), 32'h1);
    if (spurious) begin
      @(posedge clk); #1;
      start = 1'b1; src_addr = $urandom; dst_addr = $urandom; word_count = CNT_W'(5);
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 2 * n + 8 && !got; i++) begin
      if (intr) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("intr_seen", 32'(got), 32'h1);
    chk("bus_cycles", 32'(bus_cnt - b0), 32'(2 * n));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("intr_held", 32'(intr), 32'h1);
      chk("busy_held", 32'(busy), 32'h1);
    end
    inta = 1'b1;
    start = start_with_inta;
    src_addr = 32'h0000_1000; dst_addr = 32'h0000_1100; word_count = CNT_W'(3);
    @(posedge clk); #1;
    inta = 1'b0; start = 1'b0;
    chk("intr_after_inta", 32'(intr), 32'h0);
    chk("busy_after_inta", 32'(busy), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy), 32'h0);
    chk("queue_drained", 32'(exp_q.size() + exp_intr_q.size()), 32'h0);
    for (int k = 0; k < n; k++)
      chk("dst_contents", mem_rd(d + 32'(4 * k)), ref_rd(d + 32'(4 * k)));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, d;
    int base;
    txn_t t;
    reset = 1'b1; start = 1'b0; inta = 1'b0;
    src_addr = '0; dst_addr = '0; word_count = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_io_cs", 32'(io_cs), 32'h0);
    chk("rst_strobes", 32'({io_rd, io_wr}), 32'h0);
    chk("rst_io_addr", io_addr, 32'h0);
    chk("rst_io_dout", io_dout, 32'h0);
    chk("rst_busy_intr", 32'({busy, intr}), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic two-word copy.
    poke(32'h100, 32'h1122_3344);
    poke(32'h104, 32'hAABB_CCDD);
    run_xfer(32'h100, 32'h200, 2, 1, 1'b0, 1'b0);
    chk("copy_word0", mem_rd(32'h200), 32'h1122_3344);
    chk("copy_word1", mem_rd(32'h204), 32'hAABB_CCDD);

    // Zero-length transfer.
    run_xfer(32'h100, 32'h300, 0, 2, 1'b0, 1'b0);

    // Address wrap on source, then on destination.
    poke(32'hFFFF_FFFC, 32'hDEAD_BEEF);
    poke(32'h0000_0000, 32'h0BAD_F00D);
    run_xfer(32'hFFFF_FFFC, 32'h400, 2, 0, 1'b0, 1'b0);
    run_xfer(32'h100, 32'hFFFF_FFFC, 2, 0, 1'b0, 1'b0);

    // start pulses during a 3-word transfer are ignored.
    run_xfer(32'h400, 32'h500, 3, 1, 1'b1, 1'b0);

    // Reset during the write of word 1 of 4.
    for (int i = 0; i < 8; i++) poke(32'h600 + 32'(4 * i), $urandom);
    s = 32'h600; d = 32'h610;
    src_addr = s; dst_addr = d; word_count = CNT_W'(4); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = cyc;
    for (int k = 0; k < 2; k++) begin
      t.wr = 1'b0; t.addr = s + 32'(4 * k); t.data = 32'h0; t.cyc = base + 2 * k;
      exp_q.push_back(t);
      t.wr = 1'b1; t.addr = d + 32'(4 * k); t.data = ref_rd(s + 32'(4 * k)); t.cyc = base + 2 * k + 1;
      exp_q.push_back(t);
    end
    ref_mem[d[31:2]] = ref_rd(s);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_strobes", 32'({io_cs, io_rd, io_wr}), 32'h0);
    chk("midrst_addr_dout", io_addr | io_dout, 32'h0);
    chk("midrst_busy_intr", 32'({busy, intr}), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_queue", 32'(exp_q.size()), 32'h0);
    chk("midrst_word0", mem_rd(d), ref_rd(d));
    chk("midrst_word1_untouched", mem_rd(d + 32'd4), ref_rd(d + 32'd4));

    // Long intr hold, then inta together with start.
    run_xfer(32'h600, 32'h700, 2, 10, 1'b0, 1'b1);

    // Randomized transfers over a small, possibly overlapping region.
    for (int i = 0; i < 64; i++) poke(32'h1000 + 32'(4 * i), $urandom);
    for (int r = 0; r < 12; r++) begin
      s = 32'h1000 + {22'h0, 8'($urandom_range(0, 40)), 2'b00};
      d = 32'h1000 + {22'h0, 8'($urandom_range(0, 40)), 2'b00};
      if ($urandom_range(0, 3) == 0) s[1:0] = 2'($urandom);
      run_xfer(s, d, $urandom_range(0, 7), $urandom_range(0, 3), 1'b0, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/io_block_mover.md
# io_block_mover

Bus-master copy engine for the I/O space: it drives the same chip-select/read/write word interface that the I/O memory responds to. It copies a programmed number of 32-bit big-endian words from a source byte address to a destination byte address, one read and one write per word. On completion it raises an interrupt and holds it until the processor acknowledges it. It sits beside the processor as a second initiator on the I/O port. External arbitration ensures only one master drives the port at a time.

## Interface
- CNT_W, 10: width of the word-count field (max 2^CNT_W − 1 words per transfer)
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on rising clk edge
- start  in  1  one-cycle request; honoured only in IDLE
- src_addr  in  32  source byte address, latched on accepted start
- dst_addr  in  32  destination byte address, latched on accepted start
- word_count  in  CNT_W  words to move, latched on accepted start
- inta  in  1  interrupt acknowledge from processor
- io_din  in  32  read data from I/O memory (valid combinationally while io_cs && io_rd)
- io_addr  out  32  byte address to I/O memory
- io_dout  out  32  write data to I/O memory
- io_cs  out  1  chip select
- io_rd  out  1  read strobe
- io_wr  out  1  write strobe (responder commits on rising clk edge)
- busy  out  1  high from the accepted start until inta is taken
- intr  out  1  transfer-complete interrupt

## Operation
- States: IDLE, READ, WRITE, INTR.
- IDLE: all strobes 0, io_addr = 0, io_dout = 0, busy = 0, intr = 0. On start, latch src/dst/count and set busy. If count = 0, go to INTR. Otherwise go to READ.
- READ: io_cs = 1, io_rd = 1, io_wr = 0, io_addr = src register. On the edge, capture io_din into the data register and go to WRITE.
- WRITE: io_cs = 1, io_wr = 1, io_rd = 0, io_addr = dst register, io_dout = data register. On the edge: src += 4, dst += 4, count −= 1. Go to INTR if the pre-decrement count = 1, else go to READ.
- INTR: strobes 0, intr = 1, busy = 1. On inta, go to IDLE (intr and busy drop the next cycle). Otherwise remain.
- Address arithmetic is 32-bit modulo 2^32: 0xFFFF_FFFC + 4 wraps to 0x0000_0000. The low 2 address bits are carried unchanged; no alignment is enforced.
- Ascending copy only. Overlapping ranges with dst > src are not corrected.
- start outside IDLE is ignored; it is never queued. inta outside INTR is ignored.
- start and inta high together in INTR: return to IDLE and drop start. It must be reasserted.
- io_rd and io_wr are never high in the same cycle.
- All outputs decode from registered state only; there is no input-to-output combinational path.

## Timing
- Reset values: state IDLE, every output 0, internal src/dst/count/data registers 0.
- Reset mid-transfer: the next cycle is IDLE with all outputs 0. A write already committed stays; no further access is issued.
- Start accepted at edge E0 with N ≥ 1 words:
  - busy = 1 from cycle E0+1.
  - Word k (k = 0..N−1) is read in cycle 2k+1 and written in cycle 2k+2.
  - intr = 1 from cycle 2N+1.
- N = 0: intr = 1 in cycle 1, with no bus activity.
- Throughput: 2 cycles per word, with no idle cycle between words.
- inta sampled at edge Ei in INTR: intr = 0 and busy = 0 from cycle Ei+1, and a new start is accepted at edge Ei+1.

## Test plan
- Pair with the I/O memory; preload words 0x1122_3344 and 0xAABB_CCDD at 0x100 and 0x104. Start src = 0x100, dst = 0x200, N = 2. Required: memory reads back the same words at 0x200/0x204, intr rises in cycle 5, busy = 1 in cycles 1–5, and the strobe sequence is rd, wr, rd, wr.
- N = 0: intr in cycle 1, io_cs never asserted. inta → IDLE one cycle later.
- Address wrap: src = 0xFFFF_FFFC, N = 2. Required: second read at 0x0000_0000; dst likewise increments by 4 modulo 2^32.
- Assert start in cycles 2 and 3 of a 3-word transfer. Required: ignored, and the transfer completes unchanged with exactly 6 bus cycles.
- Assert reset during the WRITE of word 1 of 4. Required: next cycle all outputs 0, word 0 present at dst, word 1 location untouched. A fresh start then behaves normally.
- Hold intr 10 cycles without inta. Required: intr and busy stay high. Pulse start together with inta: required IDLE with no new transfer started.
